// File: rtl/mem_responder.sv
// Wait-state memory responder for a multicycle core: one request at a time,
// a fixed number of wait states, then a single-cycle ready pulse with data or error.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        we_q, err_q;
  logic [31:0] addr_q, wd_q;
  logic [31:0] mem [DEPTH];

  logic          accept, enter_resp, op_we, op_bad;
  logic [31:0]   op_addr, op_wd;
  logic [AW-1:0] word_idx;

  // With no wait states RESP is entered on the capture edge itself, so the
  // operation must come straight from the inputs rather than the capture regs.
  assign accept     = (state == IDLE) && req;
  assign op_we      = accept ? we   : we_q;
  assign op_addr    = accept ? addr : addr_q;
  assign op_wd      = accept ? wd   : wd_q;
  assign op_bad     = (op_addr[1:0] != 2'b00) || (op_addr >= 32'(4 * DEPTH));
  assign word_idx   = op_addr[AW+1:2];
  assign enter_resp = (state != RESP) && (next_state == RESP);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cnt == 4'(WAIT_CYCLES - 1)) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      rd     <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt    <= '0;
        we_q   <= we;
        addr_q <= addr;
        wd_q   <= wd;
        err_q  <= op_bad;
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (enter_resp && !op_we && !op_bad)
        rd <= mem[word_idx];
    end
  end

  // Memory is deliberately not reset; the reset gate keeps an aborted write out.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_we && !op_bad)
      mem[word_idx] <= op_wd;
  end

  assign ready = (state == RESP);
  assign err   = ready && err_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of single transactions on a
// two-wait-state instance plus hand sequences for bursts, reset and zero wait.
module tb_mem_responder;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wd, rd;
  logic        ready, err, busy;

  logic        req0, we0;
  logic [31:0] addr0, wd0, rd0;
  logic        ready0, err0, busy0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .ready(ready), .err(err), .busy(busy)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wd(wd0),
    .rd(rd0), .ready(ready0), .err(err0), .busy(busy0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One transaction on the WC instance; inputs are scrambled right after the
  // capture edge so the response must come from the captured request.
  task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] got_rd, output logic got_err,
                                output int lat, output logic busy_ok, output logic dropped);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wd = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = ~w; addr = ~a; wd = ~d;
    lat = -1; busy_ok = 1'b1; got_rd = '0; got_err = 1'b0; dropped = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (ready) begin
        lat = k; got_rd = rd; got_err = err;
        break;
      end
      if (err) busy_ok = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    dropped = !ready && !busy && !err;
  endtask

  task automatic dut0_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic rdy_a, output logic err_a, output logic busy_a,
                         output logic [31:0] rd_a, output logic rdy_b, output logic busy_b);
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a; wd0 = d;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
    rdy_a = ready0; err_a = err0; busy_a = busy0; rd_a = rd0;
    @(negedge clk);
    rdy_b = ready0; busy_b = busy0;
  endtask

  initial begin
    logic [31:0] g_rd;
    logic        g_err, b_ok, drop;
    int          lat, pulses, first_at, second_at;
    logic        r_a, e_a, bz_a, r_b, bz_b;
    logic [31:0] rd_a;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFF0, 32'h0,         32'hA5A5_A5A5, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0000, 32'h0000_0042, 32'hA5A5_A5A5, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0042, 1'b0};

    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wd = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
    repeat (3) @(negedge clk);
    check_output("reset_ready", 32'(ready), 32'd0);
    check_output("reset_err",   32'(err),   32'd0);
    check_output("reset_busy",  32'(busy),  32'd0);
    check_output("reset_rd",    rd,         32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wd, g_rd, g_err, lat, b_ok, drop);
      check_output($sformatf("v%0d_rd", i),       g_rd,         vecs[i].exp_rd);
      check_output($sformatf("v%0d_err", i),      32'(g_err),   32'(vecs[i].exp_err));
      check_output($sformatf("v%0d_cycles", i),   32'(lat + 1), 32'(WC + 1));
      check_output($sformatf("v%0d_busy", i),     32'(b_ok),    32'd1);
      check_output($sformatf("v%0d_dropped", i),  32'(drop),    32'd1);
    end

    // req held for six edges on a read of word 0: exactly two accepted requests
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; wd = '0;
    pulses = 0; first_at = -1; second_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 5) req = 1'b0;
      if (ready) begin
        pulses++;
        if (first_at < 0) first_at = i + 1;
        else if (second_at < 0) second_at = i + 1;
      end
    end
    check_output("burst_pulses", 32'(pulses),    32'd2);
    check_output("burst_first",  32'(first_at),  32'd3);
    check_output("burst_second", 32'(second_at), 32'd7);
    check_output("burst_rd",     rd,             32'h0000_0042);

    // zero wait states: ready and busy in the single cycle after capture
    dut0_op(1'b1, 32'h8, 32'h0000_0077, r_a, e_a, bz_a, rd_a, r_b, bz_b);
    check_output("wc0_wr_ready",  32'(r_a),  32'd1);
    check_output("wc0_wr_err",    32'(e_a),  32'd0);
    check_output("wc0_wr_busy",   32'(bz_a), 32'd1);
    check_output("wc0_wr_rd",     rd_a,      32'd0);
    check_output("wc0_wr_ready2", 32'(r_b),  32'd0);
    check_output("wc0_wr_busy2",  32'(bz_b), 32'd0);
    dut0_op(1'b0, 32'h8, 32'h0, r_a, e_a, bz_a, rd_a, r_b, bz_b);
    check_output("wc0_rd_ready",  32'(r_a),  32'd1);
    check_output("wc0_rd_data",   rd_a,      32'h0000_0077);
    check_output("wc0_rd_busy",   32'(bz_a), 32'd1);
    check_output("wc0_rd_busy2",  32'(bz_b), 32'd0);
    dut0_op(1'b0, 32'h9, 32'h0, r_a, e_a, bz_a, rd_a, r_b, bz_b);
    check_output("wc0_bad_err",   32'(e_a),  32'd1);
    check_output("wc0_bad_rd",    rd_a,      32'h0000_0077);

    // reset while a write to 0x20 is waiting: aborted, memory keeps old word
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wd = '0;
    check_output("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_output("abort_busy",  32'(busy),  32'd0);
    check_output("abort_ready", 32'(ready), 32'd0);
    check_output("abort_rd",    rd,         32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check_output("abort_pulses", 32'(pulses), 32'd0);
    apply_stimulus(1'b0, 32'h20, 32'h0, g_rd, g_err, lat, b_ok, drop);
    check_output("abort_read_rd",     g_rd,         32'hCAFE_F00D);
    check_output("abort_read_err",    32'(g_err),   32'd0);
    check_output("abort_read_cycles", 32'(lat + 1), 32'(WC + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
